// File: rtl/step_rate_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the step/rate controller and its prescaler.
package step_rate_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int unsigned STEP_MAX_DEF = 20;

    // Tick period in clk cycles: one slow-clock half period.
    function automatic int unsigned rate_limit(input int unsigned sys_clk, input int unsigned freq);
        return sys_clk / (2 * freq);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] c);
        case (c)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/step_rate_ctrl_prescaler.sv
// Tick prescaler: counts 0..LIMIT[rate_sel]-1, with synchronous load-to-zero and enable.
module rate_prescaler
    import step_rate_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT0 = 50000000,
    parameter int unsigned LIMIT1 = 4166666,
    parameter int unsigned LIMIT2 = 1041666,
    parameter int unsigned LIMIT3 = 263157
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_zero,
    input  logic       en,
    input  logic [1:0] rate_sel,
    output logic       tc
);

    localparam int unsigned LMAX = max4(LIMIT0, LIMIT1, LIMIT2, LIMIT3);
    localparam int unsigned W    = (LMAX > 1) ? $clog2(LMAX) : 1;

    logic [W-1:0] count;
    logic [W-1:0] tc_val;

    always_comb begin
        tc_val = '0;
        case (rate_sel)
            2'd0: tc_val = W'(LIMIT0 - 1);
            2'd1: tc_val = W'(LIMIT1 - 1);
            2'd2: tc_val = W'(LIMIT2 - 1);
            2'd3: tc_val = W'(LIMIT3 - 1);
            default: tc_val = '0;
        endcase
    end

    assign tc = (count == tc_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/step_rate_ctrl.sv
// Run/pause/clear controller for the 0..STEP_MAX step sequencer with four selectable tick rates.
module step_rate_ctrl
    import step_rate_ctrl_pkg::*;
#(
    parameter int unsigned SYS_CLK  = 100000000,
    parameter int unsigned F0       = 1,
    parameter int unsigned F1       = 12,
    parameter int unsigned F2       = 48,
    parameter int unsigned F3       = 190,
    parameter int unsigned STEP_MAX = STEP_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] choose,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [4:0] step,
    output logic       tick,
    output logic       wrap,
    output logic [1:0] rate_sel,
    output logic       running,
    output logic       choose_err
);

    localparam logic [4:0] STEP_LAST = 5'(STEP_MAX);

    state_t     state;
    logic       choose_valid;
    logic [1:0] choose_idx;
    logic       rate_change;
    logic       presc_load;
    logic       presc_en;
    logic       presc_tc;
    logic       advance;

    assign choose_valid = $onehot(choose);
    assign choose_idx   = onehot_index(choose);
    assign rate_change  = choose_valid && (choose_idx != rate_sel);

    // stop freezes the count even on terminal count; a rate change restarts the period.
    assign presc_load = clear || rate_change || (state == IDLE);
    assign presc_en   = (state == RUN) && !stop;
    assign advance    = (state == RUN) && !stop && !clear && !rate_change && presc_tc;

    rate_prescaler #(
        .LIMIT0(rate_limit(SYS_CLK, F0)),
        .LIMIT1(rate_limit(SYS_CLK, F1)),
        .LIMIT2(rate_limit(SYS_CLK, F2)),
        .LIMIT3(rate_limit(SYS_CLK, F3))
    ) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_zero(presc_load),
        .en       (presc_en),
        .rate_sel (rate_sel),
        .tc       (presc_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            tick       <= 1'b0;
            wrap       <= 1'b0;
            rate_sel   <= '0;
            running    <= 1'b0;
            choose_err <= 1'b0;
        end else begin
            tick       <= advance;
            wrap       <= advance && (step == STEP_LAST);
            choose_err <= !choose_valid;

            if (rate_change)
                rate_sel <= choose_idx;

            if (advance)
                step <= (step == STEP_LAST) ? '0 : step + 5'd1;

            if (clear) begin
                state   <= IDLE;
                step    <= '0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: if (stop) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                    PAUSED: if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_rate_ctrl.sv
// Self-checking bench for step_rate_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_step_rate_ctrl;

    localparam int unsigned SYS = 9120;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] choose = 4'b0000;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [4:0] step;
    logic       tick, wrap, running, choose_err;
    logic [1:0] rate_sel;

    always #5 clk = ~clk;

    step_rate_ctrl #(
        .SYS_CLK(SYS), .F0(1), .F1(12), .F2(48), .F3(190), .STEP_MAX(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .choose(choose), .start(start), .stop(stop), .clear(clear),
        .step(step), .tick(tick), .wrap(wrap), .rate_sel(rate_sel), .running(running),
        .choose_err(choose_err)
    );

    int unsigned lim [4];
    int m_mode, m_cnt, m_step, m_rate, m_tick, m_wrap, m_err;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_step = 0; m_rate = 0;
        m_tick = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_update();
        bit onehot, rchg;
        int idx;
        onehot = ($countones(choose) == 1);
        idx    = choose[1] ? 1 : choose[2] ? 2 : choose[3] ? 3 : 0;
        rchg   = onehot && (idx != m_rate);
        m_tick = 0;
        m_wrap = 0;
        m_err  = onehot ? 0 : 1;
        if (clear) begin
            m_mode = M_IDLE; m_step = 0; m_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            m_cnt = 0;
            if (start) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (stop) m_mode = M_PAUSED;
            else if (!rchg) begin
                if (m_cnt == int'(lim[m_rate]) - 1) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    m_wrap = (m_step == 20) ? 1 : 0;
                    m_step = (m_step + 1) % 21;
                end else m_cnt++;
            end
        end else begin
            if (start) m_mode = M_RUN;
        end
        if (rchg) begin
            m_rate = idx;
            m_cnt  = 0;
        end
    endtask

    task automatic check_outputs();
        chk("tick", tick, m_tick);
        chk("wrap", wrap, m_wrap);
        chk("step", step, m_step);
        chk("rate_sel", rate_sel, m_rate);
        chk("running", running, (m_mode == M_RUN) ? 1 : 0);
        chk("choose_err", choose_err, m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < bound);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 4; i++) begin
            int unsigned f;
            f = (i == 0) ? 1 : (i == 1) ? 12 : (i == 2) ? 48 : 190;
            lim[i] = SYS / (2 * f);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Reset asserted mid-RUN at step 7
        choose = 4'b1000;
        cyc();
        pulse_start();
        for (int k = 0; k < 7; k++) wait_tick(100, n);
        chk("pre_reset_step", step, 7);
        repeat (3) cyc();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_step", step, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 0);
        chk("rst_rate_sel", rate_sel, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("idle_after_reset", running, 0);

        // Rate 3: first tick 24 cycles after the start edge, then every 24
        pulse_start();
        wait_tick(100, n);
        chk("first_tick_gap", n, 24);
        wait_tick(100, n);
        chk("second_tick_gap", n, 24);
        chk("step_after_two", step, 2);

        // Wrap 20 -> 0
        for (int k = 0; k < 18; k++) wait_tick(100, n);
        chk("step_at_max", step, 20);
        wait_tick(100, n);
        chk("wrap_step", step, 0);
        chk("wrap_flag", wrap, 1);
        chk("wrap_tick", tick, 1);
        for (int k = 0; k < 5; k++) wait_tick(100, n);
        chk("step_before_pause", step, 5);

        // Pause 10 cycles into the period, resume: 14 cycles remain
        repeat (10) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        repeat (100) cyc();
        chk("paused_step", step, 5);
        chk("paused_running", running, 0);
        pulse_start();
        wait_tick(100, n);
        chk("resume_gap", n, 14);
        chk("resume_step", step, 6);

        // Rate change on the terminal-count cycle suppresses the tick
        repeat (23) cyc();
        choose = 4'b0100;
        cyc();
        chk("switch_no_tick", tick, 0);
        chk("switch_rate_sel", rate_sel, 2);
        wait_tick(200, n);
        chk("rate2_gap", n, 95);

        // Invalid choose patterns flag an error without disturbing the rate
        choose = 4'b0110; cyc();
        chk("multi_hot_err", choose_err, 1);
        chk("multi_hot_rate", rate_sel, 2);
        choose = 4'b0000; cyc();
        chk("zero_err", choose_err, 1);
        choose = 4'b0100; cyc();
        chk("err_cleared", choose_err, 0);
        wait_tick(200, n);
        chk("gap_after_err", n, 92);

        // clear + stop + start together -> IDLE
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        cyc();
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        chk("clear_running", running, 0);
        chk("clear_step", step, 0);
        repeat (30) cyc();
        chk("clear_stays_idle", step, 0);

        // Random traffic against the model
        for (int it = 0; it < 5000; it++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 15) choose = 4'($urandom_range(0, 15));
            else if (r < 45) begin
                case ($urandom_range(0, 2))
                    0: choose = 4'b0010;
                    1: choose = 4'b0100;
                    default: choose = 4'b1000;
                endcase
            end
            start = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 2);
            clear = ($urandom_range(0, 199) < 1);
            cyc();
            start = 1'b0; stop = 1'b0; clear = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
